fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register of the in-order core. Drives PC-sequential requests to instruction memory over a valid/ready request channel with in-order responses, and presents fetched instructions to decode through the IF/ID register. Consumes `stall` from the hazard unit and branch/jump redirects from EX. Discards stale responses after a redirect.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: one outstanding valid/ready imem request, in-order responses,
// response-to-IF/ID latency of one cycle; a stalled response parks in a hold buffer, redirects flush and drop stale data.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, req_pc, hold_pc, hold_instr;
  logic [31:0] redirect_tgt;
  logic        adv, req_acc, ld_rsp, ld_hold, capture;

  assign redirect_tgt = redirect_pc & ~32'h3;

  always_comb begin
    adv            = !if_id_valid || !stall;
    imem_req_addr  = pc;
    imem_req_valid = 1'b0;
    ld_rsp         = 1'b0;
    ld_hold        = 1'b0;
    capture        = 1'b0;
    state_nxt      = state;

    case (state)
      IDLE:    imem_req_valid = 1'b1;
      WAIT:    imem_req_valid = imem_rsp_valid && adv;
      default: imem_req_valid = 1'b0;
    endcase
    if (!rst_n || redirect_valid) imem_req_valid = 1'b0;
    req_acc = imem_req_valid && imem_req_ready;

    if (redirect_valid) begin
      // Flush wins over stall and any same-cycle response.
      case (state)
        WAIT:    state_nxt = imem_rsp_valid ? IDLE : DROP;
        HOLD:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end else begin
      case (state)
        IDLE: if (req_acc) state_nxt = WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            if (adv) begin
              ld_rsp    = 1'b1;
              state_nxt = req_acc ? WAIT : IDLE;
            end else begin
              capture   = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (adv) begin
            ld_hold   = 1'b1;
            state_nxt = IDLE;
          end
        end
        DROP: if (imem_rsp_valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_pc      <= 32'h0;
      hold_pc     <= 32'h0;
      hold_instr  <= NOP;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP;
    end else begin
      state <= state_nxt;
      if (redirect_valid)
        pc <= redirect_tgt;
      else if (req_acc)
        pc <= pc + 32'd4;
      if (req_acc) req_pc <= pc;
      if (capture) begin
        hold_pc    <= req_pc;
        hold_instr <= imem_rsp_data;
      end
      // A consumed instruction is cleared so decode never sees it twice.
      if (redirect_valid) begin
        if_id_valid <= 1'b0;
      end else if (ld_rsp) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc;
        if_id_instr <= imem_rsp_data;
      end else if (ld_hold) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= hold_pc;
        if_id_instr <= hold_instr;
      end else if (adv) begin
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected decode-visible instructions queue up as stimulus is issued
// and a negedge monitor compares every instruction decode consumes; cycle-level checks cover requests and flushes.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_req(input string name, input logic v, input logic [31:0] a);
    check_bit({name, "_req_valid"}, imem_req_valid, v);
    if (v) check({name, "_req_addr"}, imem_req_addr, a);
  endtask

  task automatic check_reset(input string name);
    check_bit({name, "_if_id_valid"}, if_id_valid, 1'b0);
    check({name, "_if_id_pc"}, if_id_pc, 32'h0);
    check({name, "_if_id_instr"}, if_id_instr, 32'h0000_0013);
    check_bit({name, "_req_valid"}, imem_req_valid, 1'b0);
  endtask

  // Drive one cycle of inputs just after posedge, return at negedge for sampling.
  task automatic cyc(input logic rn, input logic st, input logic rv, input logic [31:0] rp,
                     input logic rdy, input logic rsv, input logic [31:0] rsd);
    @(posedge clk);
    #1;
    rst_n          = rn;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_req_ready = rdy;
    imem_rsp_valid = rsv;
    imem_rsp_data  = rsd;
    @(negedge clk);
  endtask

  // Decode consumes IF/ID when valid, not stalled and not flushed.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_id_valid === 1'b1 && stall === 1'b0 && redirect_valid === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %h instr %h, required no instruction", if_id_pc, if_id_instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_pc", if_id_pc, mon_e.pc);
        check("mon_instr", if_id_instr, mon_e.instr);
      end
    end
  end

  initial begin
    // Reset for two cycles
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_reset("rst");

    // First request right after release
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("first", 1'b1, 32'h100);

    // Streaming, 1-cycle memory, no bubbles
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4 * i);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, mem(a));
      exp_q.push_back({a, mem(a)});
      check_req("stream", 1'b1, a + 32'd4);
      if (i > 0) begin
        check_bit("stream_valid", if_id_valid, 1'b1);
        check("stream_pc", if_id_pc, a - 32'd4);
      end
    end

    // Response for 0x110 arrives while stalled -> held
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, mem(32'h110));
    check_req("stall_rsp", 1'b0, 32'h0);
    check("stall_rsp_pc", if_id_pc, 32'h10C);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("hold", 1'b0, 32'h0);
    check_bit("hold_valid", if_id_valid, 1'b1);
    check("hold_pc", if_id_pc, 32'h10C);
    check("hold_instr", if_id_instr, mem(32'h10C));
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("unstall", 1'b0, 32'h0);
    exp_q.push_back({32'h110, mem(32'h110)});
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("held_out_pc", if_id_pc, 32'h110);
    check_req("after_hold", 1'b1, 32'h114);

    // Redirect while WAIT (0x114 outstanding), target 0x203 -> 0x200
    cyc(1'b1, 1'b0, 1'b1, 32'h203, 1'b1, 1'b0, 32'h0);
    check_req("redir_cycle", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_bit("redir_flush", if_id_valid, 1'b0);
    check_req("drop_wait", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check_req("drop_rsp", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("redir_target", 1'b1, 32'h200);
    check_bit("stale_dropped", if_id_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, mem(32'h200));
    check_req("redir_next", 1'b1, 32'h204);

    // Redirect + stall + response together: flush wins
    cyc(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1, mem(32'h204));
    check("combo_pre_pc", if_id_pc, 32'h200);
    check_req("combo_cycle", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_bit("combo_flush", if_id_valid, 1'b0);
    check_req("combo_target", 1'b1, 32'h300);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, mem(32'h300));
    exp_q.push_back({32'h300, mem(32'h300)});
    check_req("combo_next", 1'b1, 32'h304);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("wait_norsp", 1'b0, 32'h0);

    // Reset mid-operation with 0x304 in flight
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_reset("rst2");
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check_req("rst2_first", 1'b1, 32'h100);

    // Backpressure: 0x104 held for 3 cycles, then accepted once
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, mem(32'h100));
    exp_q.push_back({32'h100, mem(32'h100)});
    check_req("bp0", 1'b1, 32'h104);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_req("bp1", 1'b1, 32'h104);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_req("bp2", 1'b1, 32'h104);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("bp_accept", 1'b1, 32'h104);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, mem(32'h104));
    exp_q.push_back({32'h104, mem(32'h104)});
    check_req("bp_next", 1'b1, 32'h108);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, mem(32'h108));
    exp_q.push_back({32'h108, mem(32'h108)});
    check("bp_out_pc", if_id_pc, 32'h104);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("bp_out2_pc", if_id_pc, 32'h108);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_bit("drained_valid", if_id_valid, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
